// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, its IF/D requesters and one memory2c port.
// slave: arbiter side; master: requesters and memory side.
interface mem_port_arbiter_if;
    localparam int unsigned XLEN = 32;

    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_wr;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            mem_enable;
    logic            mem_wr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data_in;
    logic [XLEN-1:0] mem_data_out;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_enable, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_data_out,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_enable, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory2c port between instruction fetch and load/store requesters.
// Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

    typedef struct packed {
        logic            wr;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } xact_t;

    if (MEM_LATENCY == 0 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be 1..15");
    end
    if (MAX_DATA_STREAK == 0 || MAX_DATA_STREAK > 15) begin : g_bad_streak
        $error("mem_port_arbiter: MAX_DATA_STREAK must be 1..15");
    end

    state_t           state, state_next;
    owner_t           owner, owner_next;
    xact_t            xact, xact_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [XLEN-1:0]  if_rdata_q, if_rdata_next;
    logic [XLEN-1:0]  d_rdata_q, d_rdata_next;

    logic pick_if_c;
    logic if_gnt_c;
    logic d_gnt_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

    logic [CNT_W-1:0] streak, streak_next;

    // IF wins a contested slot once D has taken STREAK_MAX grants in a row
    assign pick_if_c = bus.if_req & (~bus.d_req | (streak == STREAK_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else begin
            streak <= streak_next;
        end
    end

    always_comb begin
        streak_next = streak;
        if (d_gnt_c) begin
            if (!bus.if_req) begin
                streak_next = '0;
            end else if (streak != {CNT_W{1'b1}}) begin
                streak_next = streak + CNT_W'(1);
            end
        end else if (if_gnt_c) begin
            streak_next = '0;
        end
    end
`else
    assign pick_if_c = bus.if_req & ~bus.d_req;
`endif

    // grants only from IDLE; held low while reset is asserted
    assign if_gnt_c = (state == IDLE) & rst & pick_if_c;
    assign d_gnt_c  = (state == IDLE) & rst & bus.d_req & ~pick_if_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            xact       <= '0;
            cnt        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            xact       <= xact_next;
            cnt        <= cnt_next;
            if_rdata_q <= if_rdata_next;
            d_rdata_q  <= d_rdata_next;
        end
    end

    always_comb begin
        state_next    = state;
        owner_next    = owner;
        xact_next     = xact;
        cnt_next      = cnt;
        if_rdata_next = if_rdata_q;
        d_rdata_next  = d_rdata_q;
        unique case (state)
            IDLE: begin
                if (if_gnt_c) begin
                    owner_next      = OWN_IF;
                    xact_next.wr    = 1'b0;
                    xact_next.addr  = bus.if_addr;
                    xact_next.wdata = '0;
                    cnt_next        = CNT_W'(MEM_LATENCY - 1);
                    state_next      = BUSY;
                end else if (d_gnt_c) begin
                    owner_next      = OWN_D;
                    xact_next.wr    = bus.d_wr;
                    xact_next.addr  = bus.d_addr;
                    xact_next.wdata = bus.d_wdata;
                    cnt_next        = CNT_W'(MEM_LATENCY - 1);
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    // stores leave both read-data registers untouched
                    if (!xact.wr) begin
                        if (owner == OWN_D) begin
                            d_rdata_next = bus.mem_data_out;
                        end else begin
                            if_rdata_next = bus.mem_data_out;
                        end
                    end
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.if_gnt      = if_gnt_c;
    assign bus.d_gnt       = d_gnt_c;
    assign bus.if_rvalid   = (state == RESP) & (owner == OWN_IF);
    assign bus.d_rvalid    = (state == RESP) & (owner == OWN_D);
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.mem_enable  = (state == BUSY);
    assign bus.mem_wr      = (state == BUSY) & xact.wr;
    assign bus.mem_addr    = (state == BUSY) ? xact.addr : '0;
    assign bus.mem_data_in = (state == BUSY) ? xact.wdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory2c port between instruction fetch (IF) and load/store (D) requesters. This allows a unified instruction/data memory instead of separate Imem/Dmem instances.
- Sits between the pc/fetch path and the ALU-addressed data path on one side, and a single memory2c instance on the other.
- Serializes transactions with a small FSM, latches address/data/command, counts memory latency, and returns read data with a one-cycle valid pulse.

Parameters:
- MEM_LATENCY, 1: cycles mem_enable is held per transaction; read data is sampled on the last of these cycles. Legal range 1..15.
- MAX_DATA_STREAK, 4: consecutive D grants allowed while IF waits (used only with the optional feature). Legal range 1..15.

Ports:
- clk in 1: system clock, rising edge.
- rst in 1: reset, asynchronous, active-low.
- if_req in 1: fetch request; held until if_gnt.
- if_addr in 32: fetch address.
- if_gnt out 1: fetch request accepted this cycle.
- if_rvalid out 1: one-cycle pulse; if_rdata is valid.
- if_rdata out 32: fetched instruction.
- d_req in 1: data request; held until d_gnt.
- d_wr in 1: 1 = store, 0 = load.
- d_addr in 32: data address.
- d_wdata in 32: store data.
- d_gnt out 1: data request accepted this cycle.
- d_rvalid out 1: one-cycle completion pulse, for both loads and stores.
- d_rdata out 32: load data.
- mem_enable out 1: to memory2c enable.
- mem_wr out 1: to memory2c wr.
- mem_addr out 32: to memory2c addr.
- mem_data_in out 32: to memory2c data_in.
- mem_data_out in 32: from memory2c data_out.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (rst low, asynchronous):
  - state = IDLE; latency counter = 0; owner = IF; streak = 0.
  - All outputs = 0, including if_rdata and d_rdata.
  - Any in-flight transaction is dropped; no rvalid is issued for it.
- IDLE:
  - Arbitration is combinational. Default priority is D over IF.
  - Exactly one gnt is high, in the same cycle, when any req is high.
  - On a grant: latch owner, addr, wr (IF always reads), and wdata; counter = MEM_LATENCY-1; go to BUSY.
  - No req: stay in IDLE, both gnts low.
- BUSY:
  - mem_enable = 1; mem_addr, mem_wr, mem_data_in come from the latched registers.
  - mem_wr is high only for store transactions.
  - Counter decrements each cycle. When counter == 0: capture mem_data_out into the owner's rdata register (loads/fetches only) and go to RESP.
- RESP:
  - Owner's rvalid = 1 for exactly this cycle; mem_enable = 0.
  - Go to IDLE; no grant is issued in RESP.
- Timing:
  - Throughput is one transaction per MEM_LATENCY+2 cycles.
  - Latency from gnt to rvalid is MEM_LATENCY+1 cycles.
- Data hold rules:
  - if_rdata/d_rdata hold their value until the next read completion for that owner.
  - A store does not modify d_rdata.
- Boundary cases:
  - Requests arriving during BUSY/RESP are not granted and must be held by the requester.
  - Dropping a req before gnt is legal; nothing is issued.
  - Changes to addr/wdata after gnt do not affect the in-flight transaction.
  - MEM_LATENCY = 1: BUSY lasts exactly one cycle.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A 4-bit streak counter increments on each D grant made while if_req is high.
  - It clears on any IF grant, and on any D grant made with if_req low.
  - When streak == MAX_DATA_STREAK and both reqs are high, IF is granted.
  - The counter saturates and never wraps.
- Without the macro: strict D-over-IF priority; the streak logic is absent from the netlist.

Test Plan:
- Single fetch, MEM_LATENCY = 1, memory holds 0x00500093 at 0x10; if_req with if_addr=0x10 at cycle 0 -> if_gnt in cycle 0, mem_enable in cycle 1, if_rvalid with if_rdata=0x00500093 in cycle 2.
- Store then load, d_addr=0x200: store d_wdata=0xDEADBEEF -> mem_wr=1 only during BUSY, d_rvalid pulse; d_rdata unchanged. Following load -> d_rdata=0xDEADBEEF.
- Simultaneous if_req and d_req in IDLE, feature off -> d_gnt first. if_gnt comes in the next IDLE cycle, MEM_LATENCY+2 cycles later.
- Feature on, MAX_DATA_STREAK=2, if_req and d_req held high continuously -> grant order D, D, IF, D, D, IF.
- rst driven low during BUSY of a fetch, MEM_LATENCY=4 -> all outputs 0 immediately (asynchronously). No if_rvalid ever pulses for that fetch. After rst returns high with if_req still high, a fresh grant is issued.
- MEM_LATENCY=3, a load changes d_addr from 0x40 to 0x80 the cycle after gnt -> mem_addr stays 0x40 for all 3 BUSY cycles.
